bram_playback: RTL and testbench

- Wishbone read-side counterpart to the ADC logging writer.
- Reads 32-bit words sequentially from the 8 kB blockram over Wishbone, then serializes each word LSB-first onto a 1-bit output stream with a generated bit clock.
- Replays captured bitstreams, or loads test patterns, into a DAC, modulator or loopback path.
- Double-buffered: the next word is fetched while the current word shifts out.

---
 rtl/bram_pkg.sv | 23 ++
 rtl/bram_piso32.sv | 108 ++++++++++
 rtl/bram_playback.sv | 215 +++++++++++++++++++++
 tb/tb_bram_playback.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// ---------------------------------------------------------------------------
// bram_pkg
// Definitions shared by the blockram playback reader and the ADC logging
// writer: fetch FSM state encoding, blockram word/byte addressing widths and
// the all-lanes Wishbone byte select.
// ---------------------------------------------------------------------------
package bram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    // 8 kB blockram = 2048 x 32-bit words
    localparam int BRAM_ADR_W = 11;
    // Byte offset inside a 32-bit word
    localparam int BRAM_OFS_W = 2;

    localparam logic [3:0] WB_SEL_ALL = 4'b1111;

endpackage

// File: rtl/bram_piso32.sv
// ---------------------------------------------------------------------------
// bram_piso32
// 32-bit parallel-in / serial-out shifter, LSB first, with the bit-rate
// divider and the bit clock generator.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   clr             abort: stop shifting, force dat/bit_clk low
//   load, load_dat  load a new word (bit 0 appears on dat next cycle)
//   active          a word is being shifted out (registered)
//   active_nxt      value active takes at the next edge
//   ready_for_next  last bit of the current word ends this cycle
//   dat             serial data (registered)
//   bit_clk         bit clock, high in the second half of each bit (registered)
// ---------------------------------------------------------------------------
module bram_piso32 #(
    parameter int BIT_DIV = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        load,
    input  logic [31:0] load_dat,
    output logic        active,
    output logic        active_nxt,
    output logic        ready_for_next,
    output logic        dat,
    output logic        bit_clk
);

    localparam int DIV_W = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BIT_DIV / 2);

    logic [31:0]      shift_q, shift_d;
    logic [DIV_W-1:0] div_ctr_q, div_ctr_d;
    logic [4:0]       bit_idx_q, bit_idx_d;
    logic             active_q, active_d;
    logic             dat_q, dat_d;
    logic             bit_clk_q, bit_clk_d;
    logic             bit_tick_s;

    assign bit_tick_s     = active_q && (div_ctr_q == DIV_LAST);
    assign ready_for_next = bit_tick_s && (bit_idx_q == 5'd31);

    // Next-state logic for the shifter, divider and bit clock
    always_comb begin
        shift_d   = shift_q;
        div_ctr_d = div_ctr_q;
        bit_idx_d = bit_idx_q;
        active_d  = active_q;
        dat_d     = dat_q;
        if (clr) begin
            active_d  = 1'b0;
            dat_d     = 1'b0;
            div_ctr_d = {DIV_W{1'b0}};
            bit_idx_d = 5'd0;
        end else if (load) begin
            shift_d   = load_dat;
            dat_d     = load_dat[0];
            div_ctr_d = {DIV_W{1'b0}};
            bit_idx_d = 5'd0;
            active_d  = 1'b1;
        end else if (ready_for_next) begin
            // word finished and nothing to load: go quiet
            active_d  = 1'b0;
            dat_d     = 1'b0;
            div_ctr_d = {DIV_W{1'b0}};
            bit_idx_d = 5'd0;
        end else if (bit_tick_s) begin
            shift_d   = {1'b0, shift_q[31:1]};
            dat_d     = shift_q[1];
            div_ctr_d = {DIV_W{1'b0}};
            bit_idx_d = bit_idx_q + 5'd1;
        end else if (active_q) begin
            div_ctr_d = div_ctr_q + DIV_W'(1);
        end else begin
            div_ctr_d = div_ctr_q;
        end
        // Clock derived from the next divider value so it stays aligned with dat
        bit_clk_d = active_d && (div_ctr_d >= DIV_HALF);
    end

    // Shifter state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q   <= 32'd0;
            div_ctr_q <= {DIV_W{1'b0}};
            bit_idx_q <= 5'd0;
            active_q  <= 1'b0;
            dat_q     <= 1'b0;
            bit_clk_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            div_ctr_q <= div_ctr_d;
            bit_idx_q <= bit_idx_d;
            active_q  <= active_d;
            dat_q     <= dat_d;
            bit_clk_q <= bit_clk_d;
        end
    end

    assign active     = active_q;
    assign active_nxt = active_d;
    assign dat        = dat_q;
    assign bit_clk    = bit_clk_q;

endmodule

// File: rtl/bram_playback.sv
// ---------------------------------------------------------------------------
// bram_playback
// Reads 32-bit words sequentially from blockram over Wishbone and plays them
// LSB-first on a 1-bit serial stream with a generated bit clock. One word is
// held in a holding register while the previous word shifts out.
//
// Build option: define BRAM_PLAYBACK_LOOP_EN to wrap from LAST_ADR back to 0
// and play continuously until stop or underrun (no DRAIN state).
//
// Ports:
//   wb_clk_i, reset      clock, asynchronous active-high reset
//   start, stop          one-cycle control pulses (stop wins)
//   busy                 FSM not idle or stream active
//   underrun             sticky: no word ready at a word boundary
//   word_cnt             words completely shifted out since start
//   dac_dat, dac_clk     serial data and bit clock (rises mid-bit)
//   wb_*                 Wishbone read master
// ---------------------------------------------------------------------------
import bram_pkg::*;

module bram_playback #(
    parameter int ADR_W    = BRAM_ADR_W,
    parameter int LAST_ADR = 2047,
    parameter int BIT_DIV  = 16
) (
    input  logic        wb_clk_i,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] word_cnt,
    output logic        dac_dat,
    output logic        dac_clk,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    fetch_state_e     state_q, state_d;
    logic [ADR_W-1:0] adr_ctr_q, adr_ctr_d;
    logic [31:0]      hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic             abort_q, abort_d;
    logic             underrun_q, underrun_d;
    logic [15:0]      word_cnt_q, word_cnt_d;
    logic             cyc_q, cyc_d;
    logic [3:0]       sel_q, sel_d;
    logic             busy_q, busy_d;

    logic stream_active_s, stream_nxt_s, word_end_s;
    logic shift_load_s, underrun_now_s;

    // Load when the shifter is idle or just finished a word; never while
    // aborting, so stale data is never played.
    assign shift_load_s   = hold_valid_q && !stop && !abort_q &&
                            (!stream_active_s || word_end_s);
    assign underrun_now_s = word_end_s && !hold_valid_q && !stop &&
                            (state_q != ST_DRAIN);

    bram_piso32 #(
        .BIT_DIV(BIT_DIV)
    ) u_piso (
        .clk            (wb_clk_i),
        .reset          (reset),
        .clr            (stop),
        .load           (shift_load_s),
        .load_dat       (hold_q),
        .active         (stream_active_s),
        .active_nxt     (stream_nxt_s),
        .ready_for_next (word_end_s),
        .dat            (dac_dat),
        .bit_clk        (dac_clk)
    );

    // Fetch FSM, holding register and status next-state logic
    always_comb begin
        state_d   = state_q;
        adr_ctr_d = adr_ctr_q;
        hold_d    = hold_q;
        abort_d   = abort_q;
        cyc_d     = cyc_q;
        sel_d     = sel_q;

        if (stop || shift_load_s) begin
            hold_valid_d = 1'b0;
        end else begin
            hold_valid_d = hold_valid_q;
        end

        if (word_end_s && !stop) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end else begin
            word_cnt_d = word_cnt_q;
        end

        if (underrun_now_s) begin
            underrun_d = 1'b1;
        end else begin
            underrun_d = underrun_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    adr_ctr_d  = {ADR_W{1'b0}};
                    underrun_d = 1'b0;
                    word_cnt_d = 16'd0;
                    abort_d    = 1'b0;
                    cyc_d      = 1'b1;
                    sel_d      = WB_SEL_ALL;
                    state_d    = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (cyc_q && wb_ack_i) begin
                    cyc_d = 1'b0;
                    sel_d = 4'b0000;
                    if (abort_q || stop || underrun_now_s) begin
                        // bus cycle closed; the returned word is dropped
                        abort_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        hold_d       = wb_dat_i;
                        hold_valid_d = 1'b1;
                        if (adr_ctr_q == ADR_W'(LAST_ADR)) begin
`ifdef BRAM_PLAYBACK_LOOP_EN
                            adr_ctr_d = {ADR_W{1'b0}};
                            state_d   = ST_HOLD;
`else
                            state_d   = ST_DRAIN;
`endif
                        end else begin
                            adr_ctr_d = adr_ctr_q + ADR_W'(1);
                            state_d   = ST_HOLD;
                        end
                    end
                end else if (stop || underrun_now_s) begin
                    // Wishbone cycle must complete before going idle
                    abort_d = 1'b1;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!hold_valid_q) begin
                    cyc_d   = 1'b1;
                    sel_d   = WB_SEL_ALL;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!hold_valid_q && (word_end_s || !stream_active_s)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE) || stream_nxt_s;
    end

    // Fetch FSM and status registers
    always_ff @(posedge wb_clk_i or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            adr_ctr_q    <= {ADR_W{1'b0}};
            hold_q       <= 32'd0;
            hold_valid_q <= 1'b0;
            abort_q      <= 1'b0;
            underrun_q   <= 1'b0;
            word_cnt_q   <= 16'd0;
            cyc_q        <= 1'b0;
            sel_q        <= 4'b0000;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            adr_ctr_q    <= adr_ctr_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            abort_q      <= abort_d;
            underrun_q   <= underrun_d;
            word_cnt_q   <= word_cnt_d;
            cyc_q        <= cyc_d;
            sel_q        <= sel_d;
            busy_q       <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign underrun = underrun_q;
    assign word_cnt = word_cnt_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = 1'b0;
    assign wb_sel_o = sel_q;
    assign wb_adr_o = {{(32 - ADR_W - BRAM_OFS_W){1'b0}}, adr_ctr_q, {BRAM_OFS_W{1'b0}}};

endmodule

// File: tb/tb_bram_playback.sv
`timescale 1ns/1ps
module tb_bram_playback;

    localparam int BIT_DIV  = 4;
    localparam int LAST_ADR = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        busy, underrun, dac_dat, dac_clk;
    logic [15:0] word_cnt;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_i = 32'd0;
    logic        wb_ack_i = 1'b0;

    always #5 clk = ~clk;

    bram_playback #(
        .ADR_W   (11),
        .LAST_ADR(LAST_ADR),
        .BIT_DIV (BIT_DIV)
    ) dut (
        .wb_clk_i(clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .busy    (busy),
        .underrun(underrun),
        .word_cnt(word_cnt),
        .dac_dat (dac_dat),
        .dac_clk (dac_clk),
        .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o),
        .wb_we_o (wb_we_o),
        .wb_sel_o(wb_sel_o),
        .wb_adr_o(wb_adr_o),
        .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i)
    );

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int ack_n = 0;

    logic [31:0] mem [4];
    int          delay_tab [8];
    int          req_cnt = 0;
    int          req_base = 0;
    int          wait_cnt = 0;

    logic [31:0] exp_adr_q [$];
    logic        exp_bit_q [$];
    bit          bit_chk_en = 1'b0;
    logic        prev_clk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int cur_delay();
        int i;
        i = req_cnt - req_base;
        if (i >= 0 && i < 8) return delay_tab[i];
        return 0;
    endfunction

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Wishbone slave model: ack after a per-request delay, data from mem
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_ack_i <= 1'b0;
            wait_cnt <= 0;
        end else begin
            wb_ack_i <= 1'b0;
            if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
                if (wait_cnt >= cur_delay()) begin
                    wb_ack_i <= 1'b1;
                    wb_dat_i <= mem[wb_adr_o[3:2]];
                    wait_cnt <= 0;
                    req_cnt  <= req_cnt + 1;
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end else begin
                wait_cnt <= 0;
            end
        end
    end

    // Monitor: pops expected bus addresses and serial bits
    always @(negedge clk) begin
        if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
            ack_n <= ack_n + 1;
            if (exp_adr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_read: unexpected read at 0x%0h", wb_adr_o);
            end else begin
                check("wb_adr", wb_adr_o, exp_adr_q.pop_front());
                check("wb_we", {31'd0, wb_we_o}, 32'd0);
                check("wb_sel", {28'd0, wb_sel_o}, 32'hF);
            end
        end
        if (bit_chk_en && !prev_clk && dac_clk) begin
            if (exp_bit_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dac_bit: unexpected bit %0b", dac_dat);
            end else begin
                check("dac_bit", {31'd0, dac_dat}, {31'd0, exp_bit_q.pop_front()});
            end
        end
        prev_clk <= dac_clk;
    end

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 32; i++) exp_bit_q.push_back(w[i]);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    // Wait on a DUT output reaching val; expiry counts as a failed check
    task automatic wait_cond(input int which, input logic val, input int budget, input string name);
        logic cur;
        bit   hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            case (which)
                0: cur = busy;
                1: cur = dac_dat;
                2: cur = dac_clk;
                3: cur = underrun;
                4: cur = wb_cyc_o;
                default: cur = 1'bx;
            endcase
            if (cur === val) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: not reached within %0d cycles (want %0b)", name, budget, val);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_underrun"}, {31'd0, underrun}, 32'd0);
        check({name, "_word_cnt"}, {16'd0, word_cnt}, 32'd0);
        check({name, "_dac"}, {30'd0, dac_dat, dac_clk}, 32'd0);
        check({name, "_cyc_stb"}, {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        check({name, "_sel"}, {28'd0, wb_sel_o}, 32'd0);
        check({name, "_adr"}, wb_adr_o, 32'd0);
        check({name, "_we"}, {31'd0, wb_we_o}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, a0, bad;
        mem[0] = 32'hABCD_EF01;
        mem[1] = 32'h0000_0001;
        mem[2] = 32'h8000_0000;
        mem[3] = 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) delay_tab[i] = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Full playback with 1-cycle acks, plus an ignored start while busy
        req_base = req_cnt;
`ifndef BRAM_PLAYBACK_LOOP_EN
        exp_adr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 4; i++) push_word(mem[i]);
        bit_chk_en = 1'b1;
        pulse_start();
        wait_cond(1, 1'b1, 20, "first_bit");
        t0 = cyc_n;
        repeat (100) @(negedge clk);
        pulse_start();
        wait_cond(0, 1'b0, 700, "t1_busy_fall");
        t1 = cyc_n;
        check("t1_busy_len", t1 - t0, 128 * BIT_DIV);
        check("t1_word_cnt", {16'd0, word_cnt}, 32'd4);
        check("t1_underrun", {31'd0, underrun}, 32'd0);
        check("t1_dac_idle", {30'd0, dac_dat, dac_clk}, 32'd0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (wb_cyc_o || wb_stb_o) bad++;
        end
        check("t1_no_cyc_after", bad, 0);
        check("t1_adr_left", exp_adr_q.size(), 0);
        check("t1_bits_left", exp_bit_q.size(), 0);
        bit_chk_en = 1'b0;
`else
        exp_adr_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 4; i++) push_word(mem[i]);
        push_word(mem[0]);
        bit_chk_en = 1'b1;
        pulse_start();
        bad = 1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (word_cnt >= 16'd5) begin
                bad = 0;
                break;
            end
        end
        bit_chk_en = 1'b0;
        check("loop_reach_5_words", bad, 0);
        check("loop_busy", {31'd0, busy}, 32'd1);
        check("loop_bits_left", exp_bit_q.size(), 0);
        pulse_stop();
        wait_cond(0, 1'b0, 50, "loop_busy_fall");
        check("loop_reads_done", (exp_adr_q.size() <= 2) ? 1 : 0, 1);
        exp_adr_q.delete();
        check("loop_underrun", {31'd0, underrun}, 32'd0);
`endif

        // Underrun: ack for word 1 delayed 200 cycles
        req_base = req_cnt;
        delay_tab[1] = 200;
        exp_adr_q = '{32'h0, 32'h4};
        push_word(mem[0]);
        bit_chk_en = 1'b1;
        a0 = ack_n;
        pulse_start();
        wait_cond(3, 1'b1, 400, "t2_underrun");
        check("t2_word_cnt", {16'd0, word_cnt}, 32'd1);
        check("t2_busy_pending", {31'd0, busy}, 32'd1);
        check("t2_cyc_pending", {31'd0, wb_cyc_o}, 32'd1);
        @(negedge clk);
        check("t2_dac_quiet", {30'd0, dac_dat, dac_clk}, 32'd0);
        wait_cond(0, 1'b0, 200, "t2_busy_fall");
        check("t2_acks", ack_n - a0, 2);
        check("t2_underrun_sticky", {31'd0, underrun}, 32'd1);
        check("t2_word_cnt_end", {16'd0, word_cnt}, 32'd1);
        check("t2_bits_left", exp_bit_q.size(), 0);
        check("t2_adr_left", exp_adr_q.size(), 0);
        bit_chk_en = 1'b0;
        delay_tab[1] = 0;

        // Stop while streaming with the next fetch pending
        req_base = req_cnt;
        delay_tab[1] = 10;
        exp_adr_q = '{32'h0, 32'h4};
        a0 = ack_n;
        pulse_start();
        wait_cond(2, 1'b1, 20, "t3_streaming");
        check("t3_fetch_pending", {31'd0, wb_cyc_o}, 32'd1);
        pulse_stop();
        check("t3_dac_after_stop", {30'd0, dac_dat, dac_clk}, 32'd0);
        check("t3_cyc_held", {30'd0, wb_cyc_o, wb_stb_o}, 32'd3);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dac_dat || dac_clk) bad++;
            if (!wb_cyc_o) break;
        end
        check("t3_cyc_dropped", {31'd0, wb_cyc_o}, 32'd0);
        check("t3_busy", {31'd0, busy}, 32'd0);
        repeat (40) begin
            @(negedge clk);
            if (wb_stb_o) bad++;
            if (dac_dat || dac_clk) bad++;
        end
        check("t3_quiet", bad, 0);
        check("t3_acks", ack_n - a0, 2);
        check("t3_word_cnt", {16'd0, word_cnt}, 32'd0);
        check("t3_adr_left", exp_adr_q.size(), 0);
        delay_tab[1] = 0;

        // Asynchronous reset mid-word, then restart from address 0
        req_base = req_cnt;
        exp_adr_q = '{32'h0, 32'h4};
        pulse_start();
        repeat (40) @(negedge clk);
        check("t4_busy_before", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1 check_all_zero("t4_async");
        @(negedge clk);
        reset = 1'b0;
        check("t4_adr_left", exp_adr_q.size(), 0);
        req_base = req_cnt;
        exp_adr_q = '{32'h0, 32'h4};
        pulse_start();
        wait_cond(2, 1'b1, 20, "t4_restream");
        repeat (2) @(negedge clk);
        pulse_stop();
        wait_cond(0, 1'b0, 20, "t4_busy_fall");
        check("t4_restart_adr_left", exp_adr_q.size(), 0);

        // Simultaneous start and stop: stop wins
        a0 = ack_n;
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        bad = 0;
        repeat (10) begin
            if (busy || wb_cyc_o) bad++;
            @(negedge clk);
        end
        check("t5_start_stop", bad, 0);
        check("t5_acks", ack_n - a0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
